// File: rtl/tile_ray_dispatcher.sv
// tile_ray_dispatcher
//   Front end of the ray core. Walks the frame tile by tile (row-major inside
//   a tile, tiles row-major across the frame) and presents one primary ray per
//   pixel to the surface stage. The ray direction is built incrementally so
//   that ray_dir = dir00 + x*du + y*dv (mod 2^FX_W, per component). After the
//   last pixel has been pushed the dispatcher waits for the ray core's
//   completed-pixel counter to reach the frame size, then pulses frame_done.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   start                begin a frame (only looked at while idle)
//   abort                cancel the current frame
//   cam_origin           ray origin {z,y,x}
//   cam_dir00            direction of pixel (0,0) {z,y,x}
//   cam_du, cam_dv       direction delta per +1 x / +1 y {z,y,x}
//   fifo_full            surface-stage input FIFO is full
//   pixel_counter        pixels completed by the ray core
//   add_input            push strobe (combinational)
//   pixel_x, pixel_y     coordinate of the presented ray
//   ray_origin, ray_dir  presented ray
//   reset_pixel_counter  one-cycle clear for the ray core pixel counter
//   busy                 high whenever not idle
//   frame_done           one-cycle completion pulse
module tile_ray_dispatcher #(
    parameter int FRAME_W = 160,
    parameter int FRAME_H = 120,
    parameter int TILE_W  = 8,
    parameter int TILE_H  = 8,
    parameter int FX_W    = 32
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    input  logic                         abort,
    input  logic [3*FX_W-1:0]            cam_origin,
    input  logic [3*FX_W-1:0]            cam_dir00,
    input  logic [3*FX_W-1:0]            cam_du,
    input  logic [3*FX_W-1:0]            cam_dv,
    input  logic                         fifo_full,
    input  logic [31:0]                  pixel_counter,
    output logic                         add_input,
    output logic [$clog2(FRAME_W)-1:0]   pixel_x,
    output logic [$clog2(FRAME_H)-1:0]   pixel_y,
    output logic [3*FX_W-1:0]            ray_origin,
    output logic [3*FX_W-1:0]            ray_dir,
    output logic                         reset_pixel_counter,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int XW     = $clog2(FRAME_W);
    localparam int YW     = $clog2(FRAME_H);
    localparam int TXW    = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int TYW    = (TILE_H > 1) ? $clog2(TILE_H) : 1;
    localparam int LOG_TW = $clog2(TILE_W);
    localparam int LOG_TH = $clog2(TILE_H);

    localparam logic [TXW-1:0] LX_LAST      = TXW'(TILE_W - 1);
    localparam logic [TYW-1:0] LY_LAST      = TYW'(TILE_H - 1);
    localparam logic [XW-1:0]  TX_LAST      = XW'(FRAME_W - TILE_W);
    localparam logic [YW-1:0]  TY_LAST      = YW'(FRAME_H - TILE_H);
    localparam logic [XW-1:0]  TX_STEP      = XW'(TILE_W);
    localparam logic [YW-1:0]  TY_STEP      = YW'(TILE_H);
    localparam logic [31:0]    FRAME_PIXELS = 32'(FRAME_W * FRAME_H);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t state;

    // Frame-constant camera deltas; the tile-sized steps are pre-shifted
    // once at latch time so the tile transitions need only one adder each.
    logic [3*FX_W-1:0] du_r;
    logic [3*FX_W-1:0] dv_r;
    logic [3*FX_W-1:0] du_tile_r;
    logic [3*FX_W-1:0] dv_tile_r;

    logic [3*FX_W-1:0] tile_row_dir;
    logic [3*FX_W-1:0] tile_dir;
    logic [3*FX_W-1:0] row_dir;
    logic [3*FX_W-1:0] cur_dir;

    logic [TXW-1:0] lx;
    logic [TYW-1:0] ly;
    logic [XW-1:0]  tile_x;
    logic [YW-1:0]  tile_y;

    logic [3*FX_W-1:0] cur_plus_du;
    logic [3*FX_W-1:0] row_plus_dv;
    logic [3*FX_W-1:0] tile_plus_du;
    logic [3*FX_W-1:0] trow_plus_dv;

    // Per-component wrapping add of two packed {z,y,x} vectors.
    function automatic logic [3*FX_W-1:0] vadd(input logic [3*FX_W-1:0] a,
                                               input logic [3*FX_W-1:0] b);
        logic [3*FX_W-1:0] r;
        for (int i = 0; i < 3; i++) begin
            r[i*FX_W +: FX_W] = a[i*FX_W +: FX_W] + b[i*FX_W +: FX_W];
        end
        return r;
    endfunction

    // Per-component left shift (multiply by a tile dimension).
    function automatic logic [3*FX_W-1:0] vshl(input logic [3*FX_W-1:0] a,
                                               input int sh);
        logic [3*FX_W-1:0] r;
        for (int i = 0; i < 3; i++) begin
            r[i*FX_W +: FX_W] = a[i*FX_W +: FX_W] << sh;
        end
        return r;
    endfunction

    assign cur_plus_du  = vadd(cur_dir, du_r);
    assign row_plus_dv  = vadd(row_dir, dv_r);
    assign tile_plus_du = vadd(tile_dir, du_tile_r);
    assign trow_plus_dv = vadd(tile_row_dir, dv_tile_r);

    // The current pixel is always held in cur_dir, so it drives ray_dir directly.
    assign ray_dir = cur_dir;

    // Abort suppresses the push in the same cycle it is seen.
    assign add_input = (state == ISSUE) && !fifo_full && !abort;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state               <= IDLE;
            du_r                <= '0;
            dv_r                <= '0;
            du_tile_r           <= '0;
            dv_tile_r           <= '0;
            tile_row_dir        <= '0;
            tile_dir            <= '0;
            row_dir             <= '0;
            cur_dir             <= '0;
            lx                  <= '0;
            ly                  <= '0;
            tile_x              <= '0;
            tile_y              <= '0;
            pixel_x             <= '0;
            pixel_y             <= '0;
            ray_origin          <= '0;
            reset_pixel_counter <= 1'b0;
            busy                <= 1'b0;
            frame_done          <= 1'b0;
        end else if (abort && (state != IDLE)) begin
            // Abort outranks any push or drain completion in the same cycle.
            state               <= IDLE;
            busy                <= 1'b0;
            reset_pixel_counter <= 1'b1;
            frame_done          <= 1'b0;
        end else begin
            reset_pixel_counter <= 1'b0;
            frame_done          <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state               <= LATCH;
                        busy                <= 1'b1;
                        reset_pixel_counter <= 1'b1;
                    end
                end
                LATCH: begin
                    du_r         <= cam_du;
                    dv_r         <= cam_dv;
                    du_tile_r    <= vshl(cam_du, LOG_TW);
                    dv_tile_r    <= vshl(cam_dv, LOG_TH);
                    tile_row_dir <= cam_dir00;
                    tile_dir     <= cam_dir00;
                    row_dir      <= cam_dir00;
                    cur_dir      <= cam_dir00;
                    ray_origin   <= cam_origin;
                    lx           <= '0;
                    ly           <= '0;
                    tile_x       <= '0;
                    tile_y       <= '0;
                    pixel_x      <= '0;
                    pixel_y      <= '0;
                    state        <= ISSUE;
                end
                ISSUE: begin
                    if (!fifo_full) begin
                        if (lx != LX_LAST) begin
                            lx      <= lx + TXW'(1);
                            pixel_x <= pixel_x + XW'(1);
                            cur_dir <= cur_plus_du;
                        end else if (ly != LY_LAST) begin
                            lx      <= '0;
                            ly      <= ly + TYW'(1);
                            pixel_x <= tile_x;
                            pixel_y <= pixel_y + YW'(1);
                            row_dir <= row_plus_dv;
                            cur_dir <= row_plus_dv;
                        end else if (tile_x != TX_LAST) begin
                            lx       <= '0;
                            ly       <= '0;
                            tile_x   <= tile_x + TX_STEP;
                            pixel_x  <= tile_x + TX_STEP;
                            pixel_y  <= tile_y;
                            tile_dir <= tile_plus_du;
                            row_dir  <= tile_plus_du;
                            cur_dir  <= tile_plus_du;
                        end else if (tile_y != TY_LAST) begin
                            lx           <= '0;
                            ly           <= '0;
                            tile_x       <= '0;
                            tile_y       <= tile_y + TY_STEP;
                            pixel_x      <= '0;
                            pixel_y      <= tile_y + TY_STEP;
                            tile_row_dir <= trow_plus_dv;
                            tile_dir     <= trow_plus_dv;
                            row_dir      <= trow_plus_dv;
                            cur_dir      <= trow_plus_dv;
                        end else begin
                            // Last pixel accepted: outputs keep its values.
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pixel_counter >= FRAME_PIXELS) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_ray_dispatcher.sv
// tb_tile_ray_dispatcher
//   Directed scoreboard bench for tile_ray_dispatcher on an 8x4 frame with
//   4x2 tiles. Expected rays are generated from the closed form
//   dir00 + x*du + y*dv in tile scan order and queued at frame start; each
//   observed push pops and compares the head entry.
module tb_tile_ray_dispatcher;

    localparam int FW = 8;
    localparam int FH = 4;
    localparam int TW = 4;
    localparam int TH = 2;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        abort;
    logic [95:0] cam_origin;
    logic [95:0] cam_dir00;
    logic [95:0] cam_du;
    logic [95:0] cam_dv;
    logic        fifo_full;
    logic [31:0] pixel_counter;
    logic        add_input;
    logic [2:0]  pixel_x;
    logic [1:0]  pixel_y;
    logic [95:0] ray_origin;
    logic [95:0] ray_dir;
    logic        reset_pixel_counter;
    logic        busy;
    logic        frame_done;

    tile_ray_dispatcher #(
        .FRAME_W(FW),
        .FRAME_H(FH),
        .TILE_W (TW),
        .TILE_H (TH),
        .FX_W   (32)
    ) dut (
        .clk                (clk),
        .resetn             (resetn),
        .start              (start),
        .abort              (abort),
        .cam_origin         (cam_origin),
        .cam_dir00          (cam_dir00),
        .cam_du             (cam_du),
        .cam_dv             (cam_dv),
        .fifo_full          (fifo_full),
        .pixel_counter      (pixel_counter),
        .add_input          (add_input),
        .pixel_x            (pixel_x),
        .pixel_y            (pixel_y),
        .ray_origin         (ray_origin),
        .ray_dir            (ray_dir),
        .reset_pixel_counter(reset_pixel_counter),
        .busy               (busy),
        .frame_done         (frame_done)
    );

    typedef struct {
        int          x;
        int          y;
        logic [95:0] dir;
    } exp_t;

    exp_t        sb[$];
    logic [95:0] cfg_origin;
    logic [95:0] cfg_dir00;
    logic [95:0] cfg_du;
    logic [95:0] cfg_dv;
    logic [4:0]  stall_pat;
    int          n_checks;
    int          n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [95:0] observed,
                                input logic [95:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [95:0] model_dir(input int x, input int y);
        logic [95:0] r;
        for (int i = 0; i < 3; i++) begin
            r[i*32 +: 32] = cfg_dir00[i*32 +: 32] + 32'(x) * cfg_du[i*32 +: 32]
                          + 32'(y) * cfg_dv[i*32 +: 32];
        end
        return r;
    endfunction

    // Queue every expected ray of a frame in tile scan order.
    task automatic fill_scoreboard();
        exp_t e;
        sb.delete();
        for (int ty = 0; ty < FH; ty += TH)
            for (int tx = 0; tx < FW; tx += TW)
                for (int ly = 0; ly < TH; ly++)
                    for (int lx = 0; lx < TW; lx++) begin
                        e.x   = tx + lx;
                        e.y   = ty + ly;
                        e.dir = model_dir(e.x, e.y);
                        sb.push_back(e);
                    end
    endtask

    // Pulse start, check the LATCH cycle, then scramble the camera inputs so
    // only the latched copies can produce correct rays.
    task automatic apply_stimulus();
        cam_origin    = cfg_origin;
        cam_dir00     = cfg_dir00;
        cam_du        = cfg_du;
        cam_dv        = cfg_dv;
        pixel_counter = 32'd0;
        fill_scoreboard();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check_output("latch_busy", 96'(busy), 96'(1));
        check_output("latch_rpc", 96'(reset_pixel_counter), 96'(1));
        check_output("latch_no_push", 96'(add_input), 96'(0));
        @(posedge clk);
        #1;
        cam_origin = {$urandom(), $urandom(), $urandom()};
        cam_dir00  = {$urandom(), $urandom(), $urandom()};
        cam_du     = {$urandom(), $urandom(), $urandom()};
        cam_dv     = {$urandom(), $urandom(), $urandom()};
    endtask

    // Observe n pushes (bounded), optionally stalling and pulsing start.
    task automatic run_pushes(input int n, input int stall_mode, input int start_at);
        int   pushes;
        int   cyc;
        exp_t head;
        pushes = 0;
        cyc    = 0;
        while (pushes < n && cyc < 400) begin
            @(negedge clk);
            fifo_full = (stall_mode != 0) ? stall_pat[cyc % 5] : 1'b0;
            start     = (pushes == start_at) ? 1'b1 : 1'b0;
            #1;
            head = sb[0];
            if (fifo_full) begin
                check_output("stall_no_push", 96'(add_input), 96'(0));
                check_output("stall_hold_x", 96'(pixel_x), 96'(head.x));
                check_output("stall_hold_dir", ray_dir, head.dir);
            end else begin
                check_output("push_strobe", 96'(add_input), 96'(1));
                check_output("push_x", 96'(pixel_x), 96'(head.x));
                check_output("push_y", 96'(pixel_y), 96'(head.y));
                check_output("push_dir", ray_dir, head.dir);
                check_output("push_origin", ray_origin, cfg_origin);
                void'(sb.pop_front());
                pushes++;
            end
            cyc++;
        end
        start     = 1'b0;
        fifo_full = 1'b0;
        check_output("push_count", 96'(pushes), 96'(n));
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        stall_pat     = 5'b01101;
        resetn        = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        fifo_full     = 1'b0;
        pixel_counter = 32'd0;
        cam_origin    = '0;
        cam_dir00     = '0;
        cam_du        = '0;
        cam_dv        = '0;
        #3;
        check_output("rst_busy", 96'(busy), 96'(0));
        check_output("rst_add", 96'(add_input), 96'(0));
        check_output("rst_dir", ray_dir, 96'(0));
        check_output("rst_px", 96'(pixel_x), 96'(0));
        check_output("rst_rpc", 96'(reset_pixel_counter), 96'(0));
        check_output("rst_done", 96'(frame_done), 96'(0));
        @(negedge clk);
        resetn = 1'b1;

        // Frame A: no backpressure, slow drain.
        cfg_origin = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
        cfg_dir00  = {32'h0000_1000, 32'hFFFF_0000, 32'h0000_0000};
        cfg_du     = {32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0001};
        cfg_dv     = {32'h0000_0007, 32'h0000_0003, 32'h0000_0100};
        apply_stimulus();
        run_pushes(32, 0, -1);
        pixel_counter = 32'd31;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check_output("drain_busy", 96'(busy), 96'(1));
            check_output("drain_no_push", 96'(add_input), 96'(0));
            check_output("drain_no_done", 96'(frame_done), 96'(0));
        end
        check_output("drain_hold_x", 96'(pixel_x), 96'(7));
        check_output("drain_hold_y", 96'(pixel_y), 96'(3));
        pixel_counter = 32'd32;
        @(negedge clk);
        #1;
        check_output("done_pulse", 96'(frame_done), 96'(1));
        @(negedge clk);
        #1;
        check_output("done_single", 96'(frame_done), 96'(0));
        check_output("done_idle", 96'(busy), 96'(0));

        // Frame B: toggling backpressure, fast drain.
        apply_stimulus();
        run_pushes(32, 1, -1);
        pixel_counter = 32'd32;
        @(negedge clk);
        #1;
        check_output("fastdrain_wait", 96'(frame_done), 96'(0));
        @(negedge clk);
        #1;
        check_output("fastdrain_done", 96'(frame_done), 96'(1));
        @(negedge clk);
        #1;
        check_output("fastdrain_idle", 96'(busy), 96'(0));

        // Frame C: wrapping delta, then abort after 5 pushes.
        cfg_dir00 = 96'(0);
        cfg_du    = {32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        cfg_dv    = 96'(0);
        apply_stimulus();
        run_pushes(2, 0, -1);
        @(negedge clk);
        fifo_full = 1'b1;
        #1;
        check_output("wrap_x", 96'(pixel_x), 96'(2));
        check_output("wrap_dir", 96'(ray_dir[31:0]), 96'(32'hFFFF_FFFE));
        run_pushes(3, 0, -1);
        @(negedge clk);
        abort = 1'b1;
        #1;
        check_output("abort_no_push", 96'(add_input), 96'(0));
        @(negedge clk);
        abort = 1'b0;
        #1;
        check_output("abort_idle", 96'(busy), 96'(0));
        check_output("abort_rpc", 96'(reset_pixel_counter), 96'(1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_output("abort_rpc_once", 96'(reset_pixel_counter), 96'(0));
            check_output("abort_no_done", 96'(frame_done), 96'(0));
        end

        // start together with abort in IDLE stays idle.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
        check_output("start_abort_idle", 96'(busy), 96'(0));

        // Frame D: rescan from (0,0), start pulsed in ISSUE, reset mid-frame.
        cfg_dir00 = {32'h0000_0010, 32'h0000_0020, 32'h0000_0030};
        cfg_du    = {32'h0000_0003, 32'h0000_0002, 32'h0000_0001};
        cfg_dv    = {32'hFFFF_FFF0, 32'h0000_0040, 32'h0000_0100};
        apply_stimulus();
        run_pushes(10, 1, 3);
        @(negedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check_output("mid_rst_add", 96'(add_input), 96'(0));
        check_output("mid_rst_busy", 96'(busy), 96'(0));
        check_output("mid_rst_px", 96'(pixel_x), 96'(0));
        check_output("mid_rst_py", 96'(pixel_y), 96'(0));
        check_output("mid_rst_dir", ray_dir, 96'(0));
        check_output("mid_rst_org", ray_origin, 96'(0));
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        check_output("post_rst_idle", 96'(busy), 96'(0));

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/tile_ray_dispatcher.md
Name: tile_ray_dispatcher

Overview:
- Front end of the ray core. Walks the frame in screen tiles and builds one primary ray per pixel: pixel coordinate, camera origin, and a direction computed incrementally in fixed point.
- Pushes each ray into the surface stage input FIFO under fifo_full backpressure.
- After the last push, waits until the ray core's completed-pixel counter reaches the frame size, then reports frame completion.

Parameters:
- FRAME_W, 160, frame width in pixels; must be a multiple of TILE_W.
- FRAME_H, 120, frame height in pixels; must be a multiple of TILE_H.
- TILE_W, 8, tile width; must be a power of two.
- TILE_H, 8, tile height; must be a power of two.
- FX_W, 32, width of each fixed-point vector component (signed, codebase Fixed format).

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- start  in  1  begin a frame; sampled only in IDLE
- abort  in  1  cancel the current frame
- cam_origin  in  3*FX_W  ray origin {z,y,x}
- cam_dir00  in  3*FX_W  direction for pixel (0,0)
- cam_du  in  3*FX_W  direction delta per +1 x
- cam_dv  in  3*FX_W  direction delta per +1 y
- fifo_full  in  1  surface-stage input FIFO full
- pixel_counter  in  32  pixels completed by the ray core
- add_input  out  1  push strobe to the surface stage
- pixel_x  out  clog2(FRAME_W)  x of the presented ray
- pixel_y  out  clog2(FRAME_H)  y of the presented ray
- ray_origin  out  3*FX_W  origin of the presented ray
- ray_dir  out  3*FX_W  direction of the presented ray
- reset_pixel_counter  out  1  one-cycle clear of the ray core pixel counter
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle completion pulse

Behaviour:
- Reset: state=IDLE; all registered outputs and accumulators clear to 0. This includes pixel_x, pixel_y, ray_origin, ray_dir, reset_pixel_counter and frame_done.
- States: IDLE, LATCH, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 -> LATCH.
  - busy=0.
- LATCH (exactly 1 cycle):
  - Register the camera inputs; the registered copies are used for the whole frame.
  - Load the accumulators tile_row_dir, tile_dir, row_dir, cur_dir with cam_dir00.
  - Set pixel_x=0, pixel_y=0, ray_origin=cam_origin, ray_dir=cam_dir00.
  - reset_pixel_counter=1 in this cycle only.
  - Next state: ISSUE.
- ISSUE:
  - add_input = !fifo_full. This output is combinational from state and fifo_full; it is the only combinational output.
  - The data outputs hold the current pixel and stay stable while fifo_full=1.
  - Each cycle with add_input=1 is one accepted push. On the next edge, advance to the next pixel, giving a peak throughput of 1 pixel/clk.
- Scan order:
  - Row-major inside a tile.
  - Tiles row-major across the frame.
- Direction update (every component, FX_W-bit add, two's-complement wrap, no saturation):
  - Next x inside the tile row: cur_dir += du.
  - Next row inside the tile: row_dir += dv; cur_dir = row_dir + dv.
  - Next tile to the right: tile_dir += du<<log2(TILE_W); row_dir = cur_dir = new tile_dir.
  - Next tile row: tile_row_dir += dv<<log2(TILE_H); tile_dir = row_dir = cur_dir = new tile_row_dir.
  - The resulting ray_dir must equal dir00 + x*du + y*dv, mod 2^FX_W.
- ray_origin is constant across the frame.
- The push of pixel (FRAME_W-1, FRAME_H-1) -> DRAIN. The outputs hold their last values.
- DRAIN:
  - add_input=0.
  - When pixel_counter >= FRAME_W*FRAME_H -> DONE.
- DONE: frame_done=1 for 1 cycle, then -> IDLE.
- start while busy: ignored.
- abort=1 in any non-IDLE state:
  - Next state is IDLE and add_input=0 in that same cycle.
  - No frame_done pulse.
  - reset_pixel_counter pulses for 1 cycle on the transition.
  - Abort has priority over a simultaneous push or a DRAIN completion.
- start and abort together in IDLE: abort wins and the dispatcher stays in IDLE.
- Latency:
  - start sampled at edge 0 -> LATCH.
  - The first push can occur in the cycle after LATCH.
  - frame_done asserts 1 cycle after the counter condition is seen in DRAIN.
- Reset mid-frame: immediate return to IDLE values. No pending push survives the reset.

Test Plan:
- FRAME 8x4, TILE 4x2, fifo_full=0, dir00=0, du=1, dv=0x100 -> 32 consecutive pushes.
  - First 9 pixels in order: (0,0)(1,0)(2,0)(3,0)(0,1)(1,1)(2,1)(3,1)(4,0).
  - Check: ray_dir.x = x + 256*y on every push.
- Same config, fifo_full toggling 1,0,1,1,0 -> add_input only in the not-full cycles, outputs unchanged while stalled, exactly 32 pushes total.
- After the last push, hold pixel_counter=31 for 10 cycles, then 32 -> DRAIN for all 10 cycles, a single frame_done pulse, busy=0 the following cycle.
- du=0x7FFFFFFF, dv=0 -> pixel (2,0) ray_dir.x=0xFFFFFFFE (wrap, no saturation).
- Abort after 5 pushes -> IDLE next cycle, reset_pixel_counter pulses once, no frame_done. A following start rescans from (0,0).
- start pulsed in ISSUE -> no effect; resetn deasserted mid-ISSUE -> all outputs 0 and busy=0 immediately.
